// File: rtl/ovf_sat_alu_stage.sv
// Registered signed add/subtract stage with overflow detection, optional saturation,
// a sticky overflow flag and a saturating overflow-event counter behind valid/ready.
module ovf_sat_alu_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             sat_en,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             ovf_dir,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MaxNeg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] OneW   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] OneC   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             ovf_dir_q, ovf_dir_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic [WIDTH-1:0] b_eff, raw_sum, res_calc;
    logic             a_msb, b_msb, s_msb, ovf_calc, accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        b_eff   = op_sub ? (~b + OneW) : b;
        raw_sum = a + b_eff;
        a_msb   = a[WIDTH-1];
        b_msb   = b[WIDTH-1];
        s_msb   = raw_sum[WIDTH-1];
        // Subtracting flips the sign of B, so the "same sign" test inverts.
        if (op_sub) begin
            ovf_calc = (a_msb != b_msb) && (s_msb != a_msb);
        end else begin
            ovf_calc = (a_msb == b_msb) && (s_msb != a_msb);
        end
        if (ovf_calc && sat_en) begin
            res_calc = a_msb ? MaxNeg : MaxPos;
        end else begin
            res_calc = raw_sum;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        ovf_dir_d    = ovf_dir_q;
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = res_calc;
            ovf_d       = ovf_calc;
            ovf_dir_d   = !a_msb;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A new overflow event takes priority over a simultaneous clear.
        if (accept && ovf_calc) begin
            ovf_sticky_d = 1'b1;
            if (clr_sticky) begin
                ovf_count_d = OneC;
            end else if (ovf_count_q != CntMax) begin
                ovf_count_d = ovf_count_q + OneC;
            end
        end else if (clr_sticky) begin
            ovf_sticky_d = 1'b0;
            ovf_count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            ovf_dir_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            ovf_dir_q    <= ovf_dir_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign ovf_dir    = ovf_dir_q;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: doc/ovf_sat_alu_stage.md
Name: ovf_sat_alu_stage

Overview:
Parametrised, registered signed add/subtract stage with two's-complement overflow detection, optional saturation, a sticky overflow flag and a saturating overflow-event counter. It supersedes the purely combinational 8-bit sign-check flag. It sits in the datapath between operand sources and downstream consumers, with a valid/ready handshake on both sides. One clock domain.

Parameters:
WIDTH, 8, operand/result width in bits (>=2), signed two's complement
CNT_W, 8, width of overflow event counter (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  stage can accept operands this cycle
a  input  WIDTH  signed operand A
b  input  WIDTH  signed operand B
op_sub  input  1  0: A+B, 1: A-B
sat_en  input  1  1: clamp result on overflow, 0: wrap
clr_sticky  input  1  clears ovf_sticky and ovf_count
out_valid  output  1  result register holds valid data
out_ready  input  1  downstream accepts result
result  output  WIDTH  registered signed result
ovf  output  1  overflow occurred for the current result
ovf_dir  output  1  1: positive overflow, 0: negative overflow; meaningful only when ovf=1
ovf_sticky  output  1  set by any accepted overflowing operation until cleared
ovf_count  output  CNT_W  count of accepted overflowing operations, saturates at all-ones

Behaviour:
- Reset (rst_n=0 at clock edge): out_valid, result, ovf, ovf_dir, ovf_sticky and ovf_count all go to 0. Reset mid-transaction discards the held result. clr_sticky is ignored while reset is asserted.
- in_ready = !out_valid || out_ready (combinational). No bubble under continuous flow.
- Accept: in_valid && in_ready at the edge. Result, ovf and ovf_dir are registered on the next edge, so latency is 1 cycle. out_valid is set on accept.
- out_valid clears on out_valid && out_ready with no simultaneous accept. A simultaneous accept reloads the register and out_valid stays 1.
- While out_valid && !out_ready: result, ovf and ovf_dir hold stable. in_ready=0.
- Arithmetic: compute the raw WIDTH-bit wrapped sum a + (op_sub ? ~b+1 : b). Let s = raw MSB.
  - Add overflow: a[MSB]==b[MSB] && s!=a[MSB].
  - Sub overflow: a[MSB]!=b[MSB] && s!=a[MSB].
  - ovf_dir = !a[MSB] (positive overflow when A is non-negative).
  - Sub with b = most-negative value is handled by the rule above. Example: 0 - (-128) gives ovf=1, dir=1.
- Result: if ovf && sat_en, result = 2^(WIDTH-1)-1 (dir=1) or -2^(WIDTH-1) (dir=0). Otherwise result = raw wrapped value. ovf is reported regardless of sat_en.
- Sticky and counter are updated on accept, in the same edge the result registers:
  - An overflowing accept sets ovf_sticky and increments ovf_count unless it is all-ones, where it holds.
  - clr_sticky alone: ovf_sticky=0, ovf_count=0.
  - clr_sticky with a simultaneous overflowing accept: ovf_sticky=1, ovf_count=1 (the new event wins over the clear).
- Inputs are sampled only on accept. a, b, op_sub and sat_en may change freely otherwise.

Test Plan:
1. WIDTH=8, sat_en=0, add 0x7F+0x01, out_ready=1 -> one cycle later: out_valid=1, result=0x80, ovf=1, ovf_dir=1, ovf_sticky=1, ovf_count=1.
2. sat_en=1: add 0x80+0xFF -> result=0x80, ovf=1, dir=0. Sub 0x00-0x80 -> result=0x7F, ovf=1, dir=1. Add 0x05+0xFD -> result=0x02, ovf=0.
3. Backpressure: hold out_ready=0 after an accept -> in_ready=0 and result held stable for 5 cycles. Then out_ready=1 with in_valid=1 -> back-to-back transfers at one per cycle with no lost or duplicated results.
4. CNT_W=2: 5 consecutive overflowing adds -> ovf_count goes 1, 2, 3, 3, 3. Then clr_sticky alone -> ovf_sticky=0, ovf_count=0.
5. clr_sticky asserted in the same cycle as an overflowing accept -> ovf_sticky=1, ovf_count=1. Same with a non-overflowing accept -> ovf_sticky=0, ovf_count=0.
6. Assert rst_n=0 while out_valid=1 and out_ready=0 -> next edge: all outputs 0, in_ready=1. A pending clr_sticky during reset has no effect.
